// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM and its block-copy initiator.
package ram_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } copy_state_t;

endpackage

// File: rtl/copy_addr_gen.sv
// Loadable address pointer with increment enable; wraps modulo 2^AW.
module copy_addr_gen #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + AW'(1);
        end
    end

endmodule

// File: rtl/ram_copy_dma.sv
// Block copy from RAM bank A to bank B at one word per clock; the write
// stage trails the read stage by one cycle and takes its data straight from dout_a.
module ram_copy_dma
    import ram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   words_done,
    output logic          ce,
    output logic          we_a,
    output logic [AW-1:0] adr_a,
    input  logic [DW-1:0] dout_a,
    output logic          we_b,
    output logic [AW-1:0] adr_b,
    output logic [DW-1:0] din_b
);

    copy_state_t state, state_next;
    logic        accept;
    logic        rd_issue;
    logic        wr_pend;
    logic [AW:0] remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        rd_issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // An aborted cycle issues no read; the read already in flight still lands.
                if (abort) begin
                    state_next = DRAIN;
                end else begin
                    rd_issue = 1'b1;
                    if (remaining == (AW+1)'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // wr_pend marks that dout_a holds a word read in the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pend    <= 1'b0;
            remaining  <= '0;
            words_done <= '0;
        end else begin
            wr_pend <= rd_issue;
            if (accept) begin
                remaining  <= len;
                words_done <= '0;
            end else begin
                if (rd_issue) begin
                    remaining <= remaining - (AW+1)'(1);
                end
                if (wr_pend) begin
                    words_done <= words_done + (AW+1)'(1);
                end
            end
        end
    end

    copy_addr_gen #(.AW(AW)) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (src),
        .inc      (rd_issue),
        .ptr      (adr_a)
    );

    copy_addr_gen #(.AW(AW)) u_wr_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (dst),
        .inc      (wr_pend),
        .ptr      (adr_b)
    );

    assign ce    = rd_issue | wr_pend;
    assign we_a  = 1'b0;
    assign we_b  = wr_pend;
    assign din_b = dout_a;
    assign busy  = (state == RUN) || (state == DRAIN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_ram_copy_dma.sv
// Bench for ram_copy_dma: table of copy vectors against a behavioural dual-port RAM,
// plus hand-written sequences for reset state and reset in mid-copy.
module tb_ram_copy_dma;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [AW-1:0] src, dst;
    logic [AW:0]   len;
    logic          busy, done, ce, we_a, we_b;
    logic [AW:0]   words_done;
    logic [AW-1:0] adr_a, adr_b;
    logic [DW-1:0] dout_a, din_b;

    logic [7:0] bank_a [256];
    logic [7:0] bank_b [256];
    logic       preload_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];
    logic [31:0] act_q [$];

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [8:0] len;
        int         abort_cyc;
        int         restart_cyc;
        logic [7:0] restart_src;
        int         exp_done;
        int         exp_words;
        int         exp_busy;
        int         exp_ce;
    } rec_t;

    rec_t vec [8];

    always #5 clk = ~clk;

    ram_copy_dma #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .ce         (ce),
        .we_a       (we_a),
        .adr_a      (adr_a),
        .dout_a     (dout_a),
        .we_b       (we_b),
        .adr_b      (adr_b),
        .din_b      (din_b)
    );

    // Dual-port RAM model: port A synchronous read, port B synchronous write.
    always @(posedge clk) begin
        if (ce && !we_a) dout_a <= bank_a[adr_a];
    end

    always @(posedge clk) begin
        if (preload_b) begin
            for (int i = 0; i < 256; i++) bank_b[i] <= 8'(i) ^ 8'hA5;
        end else if (ce && we_b) begin
            bank_b[adr_b] <= din_b;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_preload();
        @(posedge clk); #1;
        preload_b = 1'b1;
        @(posedge clk); #1;
        preload_b = 1'b0;
    endtask

    task automatic run_copy(input rec_t r, input string tag);
        int         k;
        int         done_off;
        int         n_done;
        int         n_busy;
        int         n_ce;
        logic [7:0] lo, hi;
        do_preload();
        exp_q.delete();
        act_q.delete();
        for (int i = 0; i < r.exp_words; i++)
            exp_q.push_back({16'(i + 2), 8'(r.dst + i), 8'(r.src + i + 8'h10)});
        @(posedge clk); #1;
        src   = r.src;
        dst   = r.dst;
        len   = r.len;
        start = 1'b1;
        k = 0; done_off = -1; n_done = 0; n_busy = 0; n_ce = 0;
        while (k < 600) begin
            @(posedge clk); #1;
            k++;
            start = (k == r.restart_cyc);
            if (start) src = r.restart_src;
            abort = (k == r.abort_cyc);
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_off < 0) done_off = k;
            end
            if (busy) n_busy++;
            if (ce) n_ce++;
            if (ce && we_b) act_q.push_back({16'(k), adr_b, din_b});
            if (done_off >= 0 && k > done_off) break;
        end
        start = 1'b0;
        abort = 1'b0;
        check({tag, " done_cycle"}, done_off, r.exp_done);
        check({tag, " done_pulses"}, n_done, 1);
        check({tag, " busy_cycles"}, n_busy, r.exp_busy);
        check({tag, " ce_cycles"}, n_ce, r.exp_ce);
        check({tag, " words_done"}, 32'(words_done), r.exp_words);
        check({tag, " write_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < act_q.size()) check($sformatf("%s write%0d", tag, i), act_q[i], exp_q[i]);
        if (r.exp_words < 256) begin
            lo = r.dst - 8'd1;
            hi = 8'(r.dst + r.exp_words);
            check({tag, " below_dst"}, bank_b[lo], lo ^ 8'hA5);
            check({tag, " past_end"}, bank_b[hi], hi ^ 8'hA5);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; preload_b = 1'b0;
        src = '0; dst = '0; len = '0;
        for (int i = 0; i < 256; i++) bank_a[i] = 8'(i + 8'h10);

        //              src     dst     len     abt rs  rs_src  done words busy ce
        vec[0] = '{8'd4,   8'd20,  9'd5,   0,  0,  8'd0,   7,   5,    6,   6};
        vec[1] = '{8'd254, 8'd253, 9'd4,   0,  0,  8'd0,   6,   4,    5,   5};
        vec[2] = '{8'd7,   8'd30,  9'd0,   0,  0,  8'd0,   1,   0,    0,   0};
        vec[3] = '{8'd0,   8'd100, 9'd10,  3,  0,  8'd0,   5,   2,    4,   3};
        vec[4] = '{8'd9,   8'd9,   9'd1,   0,  0,  8'd0,   3,   1,    2,   2};
        vec[5] = '{8'd4,   8'd40,  9'd5,   0,  2,  8'd100, 7,   5,    6,   6};
        vec[6] = '{8'd50,  8'd60,  9'd4,   1,  0,  8'd0,   3,   0,    2,   0};
        vec[7] = '{8'd0,   8'd0,   9'd256, 0,  0,  8'd0,   258, 256,  257, 257};

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst ce", ce, 0);
        check("rst we_a", we_a, 0);
        check("rst we_b", we_b, 0);
        check("rst adr_a", adr_a, 0);
        check("rst adr_b", adr_b, 0);
        check("rst words_done", words_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 8; v++) run_copy(vec[v], $sformatf("vec%0d", v));

        // Reset asserted during cycle 3 of an 8-word copy.
        begin
            int n_busy, n_we, n_done;
            n_busy = 0; n_we = 0; n_done = 0;
            do_preload();
            @(posedge clk); #1;
            src = 8'd10; dst = 8'd150; len = 9'd8; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
            @(negedge clk);
            check("rstmid words_done", words_done, 0);
            for (int c = 0; c < 6; c++) begin
                if (c > 0) @(negedge clk);
                if (busy) n_busy++;
                if (we_b) n_we++;
                if (done) n_done++;
            end
            check("rstmid busy", n_busy, 0);
            check("rstmid we_b", n_we, 0);
            check("rstmid done", n_done, 0);
            check("rstmid first_write", bank_b[150], 8'h1A);
            check("rstmid no_third_write", bank_b[152], 8'd152 ^ 8'hA5);
            run_copy(vec[0], "after_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
